sys_sum_serialiser: RTL and testbench
=====================================

// Module: sys_sum_serialiser
// PURPOSE
// - Upstream neighbour of the sys stacker. Accumulates NumOfNerves parallel signed
//   product lanes from the systolic array over KernelLen beats per window.
// - Rescales and saturates each lane sum to BitSize.
// - Emits the lanes serially, one value per cycle, on a valid/start stream.
// - Double-banked: the next window accumulates while the previous one drains.
// PARAMETERS
// - BitSize      8   output word width, signed
// - InBits       16  per-lane product width, signed
// - NumOfNerves  4   parallel lanes per window; also the output burst length
// - KernelLen    3   beats accumulated per window, >=1
// - FracShift    2   arithmetic right shift applied to each sum before saturation
// - localparam AccBits = InBits + $clog2(KernelLen) + 1
// PORTS
// - clk        in   1                     clock
// - res_n      in   1                     async reset, active low
// - in_valid   in   1                     beat present on in_data
// - in_start   in   1                     beat is first of a window (qualified by in_valid)
// - in_data    in   [NumOfNerves][InBits]  signed lane products
// - in_ready   out  1                     beat accepted when in_valid & in_ready
// - out_valid  out  1                     out_data valid
// - out_start  out  1                     first value (lane 0) of a burst
// - out_data   out  [BitSize]             signed rescaled lane sum
// - err_abort  out  1                     one-cycle pulse: window restarted before completion
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low; all flops clear immediately on res_n=0.
// - Reset state: all outputs 0 except in_ready=1; FSM in IDLE; both banks and counters cleared.
// - Accumulator FSM:
//   - IDLE->ACCUM on an accepted beat with in_start. The beat loads acc[i]=sext(in_data[i]); beat_cnt=1.
//   - In IDLE, accepted beats without in_start are dropped silently.
//   - ACCUM: an accepted beat without in_start adds into acc[i]; beat_cnt++.
//   - ACCUM + accepted beat with in_start: err_abort=1 next cycle, partial sums discarded,
//     the beat starts a new window (beat_cnt=1).
//   - Beat number KernelLen completes the window (KernelLen=1: the start beat completes it).
//     The completed sums are copied to the drain bank and the FSM returns to IDLE
//     (or stays in ACCUM if the next accepted beat starts a new window).
// - Drain bank: drain_idx runs 0..NumOfNerves-1, one value per cycle, lane 0 first.
//   - out_valid=1 for NumOfNerves consecutive cycles; out_start=1 with lane 0 only.
//   - Outputs are registered. Window-completing beat accepted at cycle N -> lane 0 at N+1.
//   - Back-to-back bursts are contiguous: no idle gap when the next bank is ready.
// - Backpressure: in_ready=0 only when the pending beat would complete a window while the
//   drain bank is busy past the current cycle (busy and drain_idx != NumOfNerves-1).
//   in_ready never depends on in_valid.
// - Arithmetic, per lane:
//   - r = (acc + (FracShift ? 1<<(FracShift-1) : 0)) >>> FracShift (round half up).
//   - Saturate r to [-2^(BitSize-1), 2^(BitSize-1)-1].
//   - Rescaling is done once at the drain-bank load, not per beat.
// - No overflow in acc by construction (AccBits).
// - Reset mid-drain or mid-window: burst truncated, partial window discarded, no err_abort.
// CONFIGURATION
// - SYS_SUM_RELU_EN defined: after saturation, negative results output as 0
//   (ReLU fused ahead of the stacker).
// - SYS_SUM_RELU_EN undefined: signed saturated values pass unchanged.
// - Timing and handshake are identical in both builds.
// TESTING
// - Defaults, 3 beats, lanes {4,8,-4,100}, in_start on beat 1
//   -> out_data 3,6,-3,75 on 4 consecutive cycles; out_start only with 3;
//      lane 0 one cycle after beat 3.
// - Lane0 3x1000, lane1 3x(-1000) -> 127, -128 (saturation both rails);
//   SYS_SUM_RELU_EN -> 127, 0.
// - Two windows streamed with in_valid=1 every cycle from cycle 0
//   -> in_ready low only in cycle 5, exactly 1 cycle;
//      bursts on cycles 3-6 and 7-10, contiguous.
// - Window of 1s, then in_start again on beat 3 -> err_abort pulse 1 cycle;
//   only the second window's burst appears.
// - in_valid beats without in_start while IDLE -> no output, in_ready stays 1.
// - res_n=0 during lane 1 of a burst -> out_valid=0 the same cycle (async);
//   after release no residual output; the next full window drains correctly.

Source files
------------

// File: rtl/sys_sum_serialiser_if.sv
// Stream bundle for sys_sum_serialiser: beat input stream, serial lane output
// stream and the abort pulse. "master" is the environment side, "slave" the
// serialiser side.
interface sys_sum_serialiser_if #(
    parameter int BitSize     = 8,
    parameter int InBits      = 16,
    parameter int NumOfNerves = 4
);
    logic                                in_valid;
    logic                                in_start;
    logic [NumOfNerves-1:0][InBits-1:0]  in_data;
    logic                                in_ready;
    logic                                out_valid;
    logic                                out_start;
    logic [BitSize-1:0]                  out_data;
    logic                                err_abort;

    modport master (
        output in_valid, in_start, in_data,
        input  in_ready, out_valid, out_start, out_data, err_abort
    );

    modport slave (
        input  in_valid, in_start, in_data,
        output in_ready, out_valid, out_start, out_data, err_abort
    );
endinterface

// File: rtl/sys_sum_serialiser.sv
// sys_sum_serialiser: accumulates NumOfNerves signed product lanes over
// KernelLen beats, rescales (round half up, arithmetic shift) and saturates
// each sum to BitSize, then emits the lanes serially, lane 0 first.
// A drain bank lets the next window accumulate while the previous one drains.
// Optional build macro: SYS_SUM_RELU_EN clamps negative results to 0.
module sys_sum_serialiser #(
    parameter int BitSize     = 8,
    parameter int InBits      = 16,
    parameter int NumOfNerves = 4,
    parameter int KernelLen   = 3,
    parameter int FracShift   = 2
) (
    input  logic                clk,
    input  logic                res_n,
    sys_sum_serialiser_if.slave bus
);
    localparam int AccBits  = InBits + $clog2(KernelLen) + 1;
    localparam int CntBits  = $clog2(KernelLen + 1);
    localparam int IdxBits  = (NumOfNerves > 1) ? $clog2(NumOfNerves) : 1;
    localparam int RoundInt = (1 << FracShift) >> 1;
    localparam logic signed [AccBits:0] RoundAdd = (AccBits + 1)'(RoundInt);
    localparam logic signed [AccBits:0] SatMax   = (AccBits + 1)'((1 << (BitSize - 1)) - 1);
    localparam logic signed [AccBits:0] SatMin   = (AccBits + 1)'(-(1 << (BitSize - 1)));

    typedef enum logic {IDLE, ACCUM} state_t;

    // Round half up, shift, saturate to the output rails (optionally ReLU).
    function automatic logic [BitSize-1:0] rescale(input logic signed [AccBits-1:0] sum);
        logic signed [AccBits:0] wide;
        logic signed [AccBits:0] shifted;
        logic [BitSize-1:0]      sat;
        wide    = {sum[AccBits-1], sum};
        shifted = (wide + RoundAdd) >>> FracShift;
        if (shifted > SatMax) begin
            sat = SatMax[BitSize-1:0];
        end else if (shifted < SatMin) begin
            sat = SatMin[BitSize-1:0];
        end else begin
            sat = shifted[BitSize-1:0];
        end
`ifdef SYS_SUM_RELU_EN
        if (sat[BitSize-1]) begin
            sat = '0;
        end
`endif
        return sat;
    endfunction

    state_t                    state_reg, state_next;
    logic [CntBits-1:0]        beat_cnt_reg, beat_cnt_next;
    logic signed [AccBits-1:0] acc_reg  [NumOfNerves];
    logic signed [AccBits-1:0] acc_next [NumOfNerves];
    logic signed [AccBits-1:0] lane_sum [NumOfNerves];
    logic [BitSize-1:0]        lane_scaled [NumOfNerves];
    logic [BitSize-1:0]        bank_reg [NumOfNerves];
    logic [IdxBits-1:0]        drain_idx_reg, drain_idx_inc;
    logic                      out_valid_reg, out_start_reg;
    logic [BitSize-1:0]        out_data_reg;
    logic                      err_abort_reg, err_abort_next;
    logic                      ready, accept, would_complete, drain_busy, window_done;

    genvar gi;
    generate
        for (gi = 0; gi < NumOfNerves; gi++) begin : g_lane
            logic signed [AccBits-1:0] lane_in;
            assign lane_in          = AccBits'($signed(bus.in_data[gi]));
            // A start beat begins a fresh sum; otherwise extend the running one.
            assign lane_sum[gi]     = (bus.in_start ? '0 : acc_reg[gi]) + lane_in;
            assign lane_scaled[gi]  = rescale(lane_sum[gi]);

            // Per-lane running accumulator.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    acc_reg[gi] <= '0;
                end else begin
                    acc_reg[gi] <= acc_next[gi];
                end
            end

            // Drain bank captures the rescaled window when it completes.
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    bank_reg[gi] <= '0;
                end else if (window_done) begin
                    bank_reg[gi] <= lane_scaled[gi];
                end
            end
        end
    endgenerate

    // Stall only a window-completing beat while the bank still has more than
    // the current lane left to emit; in_valid is deliberately not involved.
    assign would_complete = bus.in_start ? (KernelLen == 1)
                                         : (state_reg == ACCUM &&
                                            beat_cnt_reg == CntBits'(KernelLen - 1));
    assign drain_busy     = out_valid_reg && (drain_idx_reg != IdxBits'(NumOfNerves - 1));
    assign ready          = !(would_complete && drain_busy);
    assign accept         = bus.in_valid && ready;
    assign drain_idx_inc  = drain_idx_reg + 1'b1;

    // Accumulator FSM: next state, beat count, sums and abort pulse.
    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        acc_next       = acc_reg;
        err_abort_next = 1'b0;
        window_done    = 1'b0;
        if (accept) begin
            if (bus.in_start) begin
                err_abort_next = (state_reg == ACCUM);
                if (KernelLen == 1) begin
                    window_done   = 1'b1;
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else begin
                    state_next    = ACCUM;
                    beat_cnt_next = CntBits'(1);
                    acc_next      = lane_sum;
                end
            end else if (state_reg == ACCUM) begin
                if (beat_cnt_reg == CntBits'(KernelLen - 1)) begin
                    window_done   = 1'b1;
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    acc_next      = lane_sum;
                end
            end
        end
    end

    // FSM state, beat counter and abort pulse registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            err_abort_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            err_abort_reg <= err_abort_next;
        end
    end

    // Serial drain: lane 0 goes straight to the output on completion, the
    // remaining lanes follow from the bank; a new window may chain on the last lane.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            out_valid_reg <= 1'b0;
            out_start_reg <= 1'b0;
            out_data_reg  <= '0;
            drain_idx_reg <= '0;
        end else if (window_done) begin
            out_valid_reg <= 1'b1;
            out_start_reg <= 1'b1;
            out_data_reg  <= lane_scaled[0];
            drain_idx_reg <= '0;
        end else if (out_valid_reg) begin
            out_start_reg <= 1'b0;
            if (drain_idx_reg == IdxBits'(NumOfNerves - 1)) begin
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
                drain_idx_reg <= '0;
            end else begin
                drain_idx_reg <= drain_idx_inc;
                out_data_reg  <= bank_reg[drain_idx_inc];
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_start = out_start_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.err_abort = err_abort_reg;
endmodule

// File: tb/tb_sys_sum_serialiser.sv
// Testbench for sys_sum_serialiser: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based behavioural model of windows and bursts.
`timescale 1ns/1ps
module tb_sys_sum_serialiser;
    localparam int BitSize     = 8;
    localparam int InBits      = 16;
    localparam int NumOfNerves = 4;
    localparam int KernelLen   = 3;
    localparam int FracShift   = 2;

    typedef int lanes_t [NumOfNerves];
    typedef struct {int val; bit first;} out_t;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    sys_sum_serialiser_if #(.BitSize(BitSize), .InBits(InBits), .NumOfNerves(NumOfNerves)) bus();

    sys_sum_serialiser #(
        .BitSize(BitSize), .InBits(InBits), .NumOfNerves(NumOfNerves),
        .KernelLen(KernelLen), .FracShift(FracShift)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    out_t mq[$];          // values still to appear on the output, current one first
    bit   m_inwin = 0;
    int   m_cnt   = 0;
    int   m_sum [NumOfNerves];
    bit   m_err   = 0;

    function automatic int rescale_ref(int s);
        int div, num, r;
        div = 1 << FracShift;
        num = s + div / 2;
        if (num >= 0) r = num / div;
        else          r = -((-num + div - 1) / div);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef SYS_SUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic bit model_ready(bit start);
        bit completes;
        completes = start ? (KernelLen == 1) : (m_inwin && m_cnt == KernelLen - 1);
        return !(completes && mq.size() > 1);
    endfunction

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            mq.delete();
            m_inwin = 0;
            m_cnt   = 0;
            m_err   = 0;
        end else begin
            bit acc;
            acc = bus.in_valid && model_ready(bus.in_start);
            if (mq.size() > 0) void'(mq.pop_front());
            m_err = 0;
            if (acc) begin
                if (bus.in_start) begin
                    m_err   = m_inwin;
                    m_inwin = 1;
                    m_cnt   = 0;
                    foreach (m_sum[i]) m_sum[i] = 0;
                end
                if (m_inwin) begin
                    foreach (m_sum[i]) m_sum[i] += int'($signed(bus.in_data[i]));
                    m_cnt++;
                    if (m_cnt == KernelLen) begin
                        for (int i = 0; i < NumOfNerves; i++)
                            mq.push_back('{val: rescale_ref(m_sum[i]), first: (i == 0)});
                        m_inwin = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit ev, ef;
        int evl;
        ev  = (mq.size() > 0);
        ef  = 0;
        evl = 0;
        if (ev) begin
            ef  = mq[0].first;
            evl = mq[0].val;
        end
        check("out_valid", bus.out_valid, ev);
        check("out_start", bus.out_start, ef);
        if (ev) check("out_data", $signed(bus.out_data), evl);
        check("err_abort", bus.err_abort, m_err);
        check("in_ready", bus.in_ready, model_ready(bus.in_start));
    end

    // Event recorder for the directed scenarios.
    int cap_val[$];
    int start_cyc[$];
    int rdy_low_cyc[$];
    int valid_cnt = 0;
    int err_cnt   = 0;
    always @(negedge clk) begin
        if (res_n) begin
            if (bus.out_valid) begin
                cap_val.push_back(int'($signed(bus.out_data)));
                valid_cnt++;
            end
            if (bus.out_start) start_cyc.push_back(cyc);
            if (!bus.in_ready) rdy_low_cyc.push_back(cyc);
            if (bus.err_abort) err_cnt++;
        end
    end

    task automatic clear_mon();
        cap_val.delete();
        start_cyc.delete();
        rdy_low_cyc.delete();
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(bit v, bit s, lanes_t d);
        @(posedge clk);
        #2;
        bus.in_valid = v;
        bus.in_start = s;
        for (int i = 0; i < NumOfNerves; i++) bus.in_data[i] = InBits'(d[i]);
    endtask

    task automatic send_beat(bit s, lanes_t d, output int acc_cyc);
        int w;
        drive(1'b1, s, d);
        #1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk);
            #3;
            w++;
        end
        check("ready_wait_bound", (w < 50), 1);
        acc_cyc = cyc;
    endtask

    task automatic idle(int n);
        lanes_t z;
        z = '{0, 0, 0, 0};
        repeat (n) drive(1'b0, 1'b0, z);
    endtask

    task automatic send_window(lanes_t d, output int last_cyc);
        int c;
        send_beat(1'b1, d, c);
        for (int b = 1; b < KernelLen; b++) send_beat(1'b0, d, c);
        last_cyc = c;
    endtask

    initial begin
        lanes_t d, d2;
        int c, c3, t0;

        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_err_abort", bus.err_abort, 0);
        @(posedge clk); #2;
        res_n = 1'b1;
        idle(2);

        // Basic window {4,8,-4,100} x3 -> 3,6,-3,75
        clear_mon();
        d = '{4, 8, -4, 100};
        send_window(d, c3);
        idle(6);
        check("basic_count", cap_val.size(), 4);
        if (cap_val.size() == 4) begin
            check("basic_lane0", cap_val[0], 3);
            check("basic_lane1", cap_val[1], 6);
            check("basic_lane2", cap_val[2], -3);
            check("basic_lane3", cap_val[3], 75);
        end
        check("basic_starts", start_cyc.size(), 1);
        if (start_cyc.size() == 1) check("basic_latency", start_cyc[0] - c3, 1);

        // Saturation on both rails
        clear_mon();
        d = '{1000, -1000, 0, 0};
        send_window(d, c3);
        idle(6);
        check("sat_count", cap_val.size(), 4);
        if (cap_val.size() == 4) begin
            check("sat_high", cap_val[0], 127);
`ifdef SYS_SUM_RELU_EN
            check("sat_low_relu", cap_val[1], 0);
`else
            check("sat_low", cap_val[1], -128);
`endif
        end

        // Two windows streamed back to back
        clear_mon();
        d  = '{1, 2, 3, 4};
        d2 = '{-8, 16, 40, -2};
        send_beat(1'b1, d, t0);
        send_beat(1'b0, d, c);
        send_beat(1'b0, d, c);
        send_beat(1'b1, d2, c);
        send_beat(1'b0, d2, c);
        send_beat(1'b0, d2, c);
        idle(8);
        check("stream_ready_low_count", rdy_low_cyc.size(), 1);
        if (rdy_low_cyc.size() == 1) check("stream_ready_low_cycle", rdy_low_cyc[0] - t0, 5);
        check("stream_bursts", start_cyc.size(), 2);
        if (start_cyc.size() == 2) begin
            check("stream_burst0", start_cyc[0] - t0, 3);
            check("stream_burst1", start_cyc[1] - t0, 7);
        end
        check("stream_valid_cycles", valid_cnt, 8);

        // Abort: window of 1s restarted on beat 3 by a window of 2s
        clear_mon();
        d  = '{1, 1, 1, 1};
        d2 = '{2, 2, 2, 2};
        send_beat(1'b1, d, c);
        send_beat(1'b0, d, c);
        send_window(d2, c3);
        idle(6);
        check("abort_pulses", err_cnt, 1);
        check("abort_bursts", start_cyc.size(), 1);
        check("abort_count", cap_val.size(), 4);
        if (cap_val.size() == 4) begin
            check("abort_lane0", cap_val[0], 2);
            check("abort_lane3", cap_val[3], 2);
        end

        // Beats without in_start while idle are dropped
        clear_mon();
        d = '{50, 50, 50, 50};
        for (int b = 0; b < 3; b++) send_beat(1'b0, d, c);
        idle(5);
        check("idle_drop_valid", valid_cnt, 0);
        check("idle_drop_ready_low", rdy_low_cyc.size(), 0);

        // Asynchronous reset during lane 1 of a burst
        d = '{40, -40, 0, 8};
        send_window(d, c3);
        idle(1);
        @(posedge clk); #2;
        res_n = 1'b0;
        #1;
        check("async_reset_out_valid", bus.out_valid, 0);
        check("async_reset_out_start", bus.out_start, 0);
        repeat (2) @(posedge clk);
        #2;
        res_n = 1'b1;
        clear_mon();
        idle(4);
        check("post_reset_residual", valid_cnt, 0);
        send_window(d, c3);
        idle(6);
        check("post_reset_count", cap_val.size(), 4);
        if (cap_val.size() == 4) begin
            check("post_reset_lane0", cap_val[0], 30);
`ifdef SYS_SUM_RELU_EN
            check("post_reset_lane1", cap_val[1], 0);
`else
            check("post_reset_lane1", cap_val[1], -30);
`endif
            check("post_reset_lane2", cap_val[2], 0);
            check("post_reset_lane3", cap_val[3], 6);
        end

        // Randomized traffic, checked by the per-cycle compare
        for (int k = 0; k < 1500; k++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NumOfNerves; i++) begin
                if ($urandom_range(0, 3) == 0) d[i] = int'($urandom_range(0, 65535)) - 32768;
                else                           d[i] = int'($urandom_range(0, 600)) - 300;
            end
            drive(v, s, d);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
